karat_mult_seq: RTL and testbench

- Time-multiplexed, one-level Karatsuba multiplier with a valid/ready handshake on input and output.
- The three half-width partial products share one (wI/2+1)-bit base multiplier over three cycles; a fourth cycle combines them.
- Successor to the recursive multiplier: a handshake replaces the enable/finish pulse, a tag passes through with each operation, and an optional signed mode is added.
- Sits between operand producers and downstream modular-reduction logic.

---
 rtl/karat_pkg.sv | 36 +++
 rtl/karat_mult_seq_base_mul.sv | 17 +
 rtl/karat_mult_seq.sv | 182 ++++++++++++++++++
 tb/tb_karat_mult_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/karat_pkg.sv
// Shared types and helpers for the sequential Karatsuba multiplier.
// Latency: n/a (types, constant functions, combinational combine).
// Backpressure: n/a.
package karat_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_MID  = 3'd3,
        S_SUM  = 3'd4,
        S_OUT  = 3'd5
    } karat_state_t;

    // Half of the operand width; used for elaboration-time localparams.
    function automatic int karat_half(input int w);
        return w / 2;
    endfunction

    // Width-parametrised recombination of the three partial products.
    // Inputs are 2h+2 = W+2 bits wide; the result is exact in 2W bits.
    virtual class karat_comb #(parameter int W = 64);
        static function logic [2*W-1:0] combine(input logic [W+1:0] p_hi,
                                                 input logic [W+1:0] pm,
                                                 input logic [W+1:0] p_lo);
            logic [2*W-1:0] hi_w;
            logic [2*W-1:0] pm_w;
            logic [2*W-1:0] lo_w;
            hi_w = {{(W-2){1'b0}}, p_hi};
            pm_w = {{(W-2){1'b0}}, pm};
            lo_w = {{(W-2){1'b0}}, p_lo};
            return (hi_w << W) + (pm_w << (W / 2)) + lo_w;
        endfunction
    endclass

endpackage

// File: rtl/karat_mult_seq_base_mul.sv
// Combinational wB x wB unsigned multiplier shared by all partial products.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller sequences its use.
module karat_base_mul #(
    parameter int wB = 33
) (
    input  logic [wB-1:0]   a,
    input  logic [wB-1:0]   b,
    output logic [2*wB-1:0] p
);

    // Operands are widened to the product width before multiplying.
    always_comb begin
        p = {{wB{1'b0}}, a} * {{wB{1'b0}}, b};
    end

endmodule

// File: rtl/karat_mult_seq.sv
// One-level Karatsuba multiplier, three partial products time-shared on one base multiplier.
// Latency: o_valid rises on the 4th edge after the accept edge; one op per 5 cycles max.
// Backpressure: result held in S_OUT until i_ready; o_ready only in S_IDLE or S_OUT&&i_ready.
// Optional signed (two's complement) operands: define KARAT_MULT_SEQ_SIGNED_EN.
module karat_mult_seq
    import karat_pkg::*;
#(
    parameter int wI   = 64,
    parameter int wO   = 2 * wI,
    parameter int wTAG = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [wI-1:0]   iX,
    input  logic [wI-1:0]   iY,
    input  logic [wTAG-1:0] i_tag,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [wO-1:0]   oO,
    output logic [wTAG-1:0] o_tag,
    output logic            o_busy
);

    localparam int H  = karat_half(wI);
    localparam int WB = H + 1;
    localparam int WP = 2 * WB;

    karat_state_t state;
    karat_state_t state_nxt;

    logic [wI-1:0]   x_r;
    logic [wI-1:0]   y_r;
    logic [wTAG-1:0] tag_r;
    logic [WP-1:0]   p_lo;
    logic [WP-1:0]   p_hi;
    logic [WP-1:0]   p_m;
    logic [wO-1:0]   prod_r;
    logic [wTAG-1:0] tag_o;

    logic [WB-1:0]   sx;
    logic [WB-1:0]   sy;
    logic [WB-1:0]   mul_a;
    logic [WB-1:0]   mul_b;
    logic [WP-1:0]   mul_p;
    logic [WP-1:0]   pm;
    logic [wO-1:0]   sum_u;
    logic [wO-1:0]   sum_res;
    logic [wI-1:0]   x_in;
    logic [wI-1:0]   y_in;
    logic            accept;

`ifdef KARAT_MULT_SEQ_SIGNED_EN
    logic            sign_r;
`endif

    assign o_ready = (state == S_IDLE) || ((state == S_OUT) && i_ready);
    assign accept  = i_valid && o_ready;
    assign o_valid = (state == S_OUT);
    assign o_busy  = (state != S_IDLE);
    assign oO      = prod_r;
    assign o_tag   = tag_o;

    // Operand conditioning at accept: magnitudes in signed mode, raw operands otherwise.
    always_comb begin
`ifdef KARAT_MULT_SEQ_SIGNED_EN
        x_in = iX[wI-1] ? (~iX + 1'b1) : iX;
        y_in = iY[wI-1] ? (~iY + 1'b1) : iY;
`else
        x_in = iX;
        y_in = iY;
`endif
    end

    // Half sums keep their carry, then the base multiplier operands are picked by state.
    always_comb begin
        sx    = {1'b0, x_r[H-1:0]} + {1'b0, x_r[wI-1:H]};
        sy    = {1'b0, y_r[H-1:0]} + {1'b0, y_r[wI-1:H]};
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_LO: begin
                mul_a = {1'b0, x_r[H-1:0]};
                mul_b = {1'b0, y_r[H-1:0]};
            end
            S_HI: begin
                mul_a = {1'b0, x_r[wI-1:H]};
                mul_b = {1'b0, y_r[wI-1:H]};
            end
            S_MID: begin
                mul_a = sx;
                mul_b = sy;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    karat_base_mul #(.wB(WB)) u_base_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Middle term and final recombination; the sign is applied to the unsigned result.
    always_comb begin
        pm    = p_m - p_lo - p_hi;
        sum_u = karat_comb#(wI)::combine(p_hi, pm, p_lo);
`ifdef KARAT_MULT_SEQ_SIGNED_EN
        sum_res = sign_r ? (~sum_u + 1'b1) : sum_u;
`else
        sum_res = sum_u;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fixed four-step walk, then wait in S_OUT for the consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_LO;
            S_LO:   state_nxt = S_HI;
            S_HI:   state_nxt = S_MID;
            S_MID:  state_nxt = S_SUM;
            S_SUM:  state_nxt = S_OUT;
            S_OUT: begin
                if (i_ready) begin
                    state_nxt = accept ? S_LO : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: operand capture, partial products and the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r    <= '0;
            y_r    <= '0;
            tag_r  <= '0;
            p_lo   <= '0;
            p_hi   <= '0;
            p_m    <= '0;
            prod_r <= '0;
            tag_o  <= '0;
`ifdef KARAT_MULT_SEQ_SIGNED_EN
            sign_r <= 1'b0;
`endif
        end else begin
            if (accept) begin
                x_r   <= x_in;
                y_r   <= y_in;
                tag_r <= i_tag;
`ifdef KARAT_MULT_SEQ_SIGNED_EN
                sign_r <= iX[wI-1] ^ iY[wI-1];
`endif
            end
            case (state)
                S_LO:  p_lo <= mul_p;
                S_HI:  p_hi <= mul_p;
                S_MID: p_m  <= mul_p;
                S_SUM: begin
                    prod_r <= sum_res;
                    tag_o  <= tag_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_karat_mult_seq.sv
// Directed and short random-stream bench for karat_mult_seq at wI=8.
// Latency: checks the 4-edge accept-to-valid delay on every directed op.
// Backpressure: holds i_ready low to check result stability and o_ready gating.
module tb_karat_mult_seq;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  iX;
    logic [7:0]  iY;
    logic [3:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] oO;
    logic [3:0]  o_tag;
    logic        o_busy;

    int n_vec = 0;
    int n_err = 0;

    karat_mult_seq #(.wI(8), .wTAG(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .iX      (iX),
        .iY      (iY),
        .i_tag   (i_tag),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .oO      (oO),
        .o_tag   (o_tag),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] a;
        logic [15:0] b;
`ifdef KARAT_MULT_SEQ_SIGNED_EN
        a = {{8{x[7]}}, x};
        b = {{8{y[7]}}, y};
`else
        a = {8'h00, x};
        b = {8'h00, y};
`endif
        return a * b;
    endfunction

    // Wait (bounded) for o_valid; returns edges waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string nm, input logic [7:0] x, input logic [7:0] y,
                          input logic [3:0] t, input logic [15:0] exp);
        int n;
        iX = x; iY = y; i_tag = t; i_valid = 1'b1; i_ready = 1'b1;
        #1;
        chk({nm, "_rdy"}, 16'(o_ready), 16'h1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        wait_valid(n);
        chk({nm, "_lat"}, 16'(n), 16'd4);
        chk({nm, "_prod"}, oO, exp);
        chk({nm, "_tag"}, 16'(o_tag), 16'(t));
        @(posedge clk); #1;
        chk({nm, "_done"}, 16'(o_valid), 16'h0);
    endtask

    typedef struct {
        logic [3:0]  t;
        logic [15:0] p;
    } exp_t;

    logic [7:0]  tab_x [8];
    logic [7:0]  tab_y [8];
    logic [15:0] tab_e [8];

    initial begin
        int   n;
        bit   seen;
        exp_t q[$];
        exp_t e;
        int   sent;
        int   got;
        int   cyc;
        bit   acc;

        tab_x = '{8'hFF, 8'h00, 8'h01, 8'h80, 8'hFF, 8'h7F, 8'h10, 8'hAA};
        tab_y = '{8'hFF, 8'hAB, 8'h01, 8'h80, 8'h02, 8'h81, 8'h0F, 8'h55};
`ifdef KARAT_MULT_SEQ_SIGNED_EN
        tab_e = '{16'h0001, 16'h0000, 16'h0001, 16'h4000, 16'hFFFE, 16'hC0FF, 16'h00F0, 16'hE372};
`else
        tab_e = '{16'hFE01, 16'h0000, 16'h0001, 16'h4000, 16'h01FE, 16'h3FFF, 16'h00F0, 16'h3872};
`endif

        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; iX = '0; iY = '0; i_tag = '0;
        #12;
        chk("rst_valid", 16'(o_valid), 16'h0);
        chk("rst_prod", oO, 16'h0);
        chk("rst_tag", 16'(o_tag), 16'h0);
        chk("rst_busy", 16'(o_busy), 16'h0);
        chk("rst_ready", 16'(o_ready), 16'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single op with full carries, then directed table back to back from idle.
        run_op("single", 8'hFF, 8'hFF, 4'h3, tab_e[0]);
        chk("single_idle", 16'(o_busy), 16'h0);
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("tab%0d", i), tab_x[i], tab_y[i], 4'(i + 4), tab_e[i]);
        end

        // Backpressure: result held for 10 cycles, then same-edge back-to-back accept.
        iX = 8'h12; iY = 8'h34; i_tag = 4'h5; i_valid = 1'b1; i_ready = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        wait_valid(n);
        chk("bp_lat", 16'(n), 16'd4);
        iX = 8'h05; iY = 8'h07; i_tag = 4'h9; i_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_prod", oO, 16'h03A8);
            chk("bp_hold_tag", 16'(o_tag), 16'h5);
            chk("bp_hold_valid", 16'(o_valid), 16'h1);
            chk("bp_hold_rdy", 16'(o_ready), 16'h0);
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", 16'(o_ready), 16'h1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("b2b_valid", 16'(o_valid), 16'h0);
        chk("b2b_busy", 16'(o_busy), 16'h1);
        wait_valid(n);
        chk("b2b_lat", 16'(n), 16'd4);
        chk("b2b_prod", oO, 16'h0023);
        chk("b2b_tag", 16'(o_tag), 16'h9);
        @(posedge clk); #1;

        // Reset in S_MID aborts the op and clears the result.
        iX = 8'h09; iY = 8'h09; i_tag = 4'hA; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 16'(o_valid), 16'h0);
        chk("mid_rst_prod", oO, 16'h0);
        chk("mid_rst_busy", 16'(o_busy), 16'h0);
        #2;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (o_valid) seen = 1'b1;
        end
        chk("mid_rst_noresult", 16'(seen), 16'h0);
        run_op("post_rst", 8'h02, 8'h03, 4'h1, 16'h0006);

        // Zero operand with an illegal i_valid pulse while in S_HI.
        iX = 8'h00; iY = 8'hAB; i_tag = 4'h2; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        iX = 8'hFF; iY = 8'hFF; i_tag = 4'hF; i_valid = 1'b1;
        #1;
        chk("ill_rdy", 16'(o_ready), 16'h0);
        @(posedge clk); #1;
        i_valid = 1'b0;
        wait_valid(n);
        chk("ill_lat", 16'(n + 2), 16'd4);
        chk("ill_prod", oO, 16'h0);
        chk("ill_tag", 16'(o_tag), 16'h2);
        @(posedge clk); #1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (o_valid) seen = 1'b1;
        end
        chk("ill_noextra", 16'(seen), 16'h0);

        // Random stream with random valid/ready gaps against a scoreboard.
        sent = 0; got = 0; cyc = 0; acc = 1'b0;
        i_valid = 1'b0;
        while (got < 200 && cyc < 6000) begin
            @(posedge clk); #1;
            cyc++;
            if (acc) i_valid = 1'b0;
            acc = 1'b0;
            if (!i_valid && sent < 200 && $urandom_range(0, 2) != 0) begin
                iX = 8'($urandom);
                iY = 8'($urandom);
                i_tag = 4'(sent);
                i_valid = 1'b1;
            end
            i_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", 16'h1, 16'h0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_prod", oO, e.p);
                    chk("rnd_tag", 16'(o_tag), 16'(e.t));
                end
                got++;
            end
            if (i_valid && o_ready) begin
                q.push_back('{i_tag, ref_mul(iX, iY)});
                sent++;
                acc = 1'b1;
            end
        end
        chk("rnd_count", 16'(got), 16'd200);
        i_valid = 1'b0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
